// File: rtl/sram_axi_bridge.sv
// Bridges the CPU inst/data sram-like ports onto one AXI master, one transaction in flight.
// Optional: define SRAM_AXI_EARLY_WACK_EN to acknowledge writes once AW and W have both completed.
module sram_axi_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int INST_ID = 0,
    parameter int DATA_ID = 1
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                inst_req,
    input  logic                inst_wr,
    input  logic [1:0]          inst_size,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic [DATA_W-1:0]   inst_wdata,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [1:0]          data_size,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    output logic [3:0]          arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic [2:0]          arsize,
    output logic                arvalid,
    input  logic                arready,

    input  logic [3:0]          rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic                rvalid,
    input  logic                rlast,
    output logic                rready,

    output logic [3:0]          awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [2:0]          awsize,
    output logic                awvalid,
    input  logic                awready,

    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    output logic                wlast,
    input  logic                wready,

    input  logic                bvalid,
    output logic                bready
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_RESP = 3'd4
    } state_t;

    // Byte-lane strobes; size 3 is reserved and behaves like a full word.
    function automatic logic [STRB_W-1:0] calc_strb(input logic [1:0] size,
                                                    input logic [1:0] offs);
        logic [STRB_W-1:0] one_byte;
        logic [STRB_W-1:0] two_byte;
        one_byte = {{(STRB_W-1){1'b0}}, 1'b1};
        two_byte = {{(STRB_W-2){1'b0}}, 2'b11};
        case (size)
            2'd0:    calc_strb = one_byte << offs;
            2'd1:    calc_strb = two_byte << {offs[1], 1'b0};
            2'd2:    calc_strb = {STRB_W{1'b1}};
            default: calc_strb = {STRB_W{1'b1}};
        endcase
    endfunction

    state_t              state_q,   state_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [1:0]          size_q,    size_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic [STRB_W-1:0]   wstrb_q,   wstrb_d;
    logic [3:0]          id_q,      id_d;
    logic                src_q,     src_d;
    logic                arvalid_q, arvalid_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q,  wvalid_d;

    logic                idle_s;
    logic                grant_s;
    logic                sel_data_s;
    logic                sel_wr_s;
    logic [1:0]          sel_size_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic                aw_fin_s;
    logic                w_fin_s;
    logic                wr_fin_s;
    logic                rd_done_s;
    logic                rd_ok_s;
    logic                wr_ack_s;

    // Request selection: the data port always wins when both are asking.
    always_comb begin
        idle_s      = (state_q == IDLE) && !rst;
        sel_data_s  = data_req;
        grant_s     = idle_s && (data_req || inst_req);
        if (sel_data_s) begin
            sel_wr_s    = data_wr;
            sel_size_s  = data_size;
            sel_addr_s  = data_addr;
            sel_wdata_s = data_wdata;
        end else begin
            sel_wr_s    = inst_wr;
            sel_size_s  = inst_size;
            sel_addr_s  = inst_addr;
            sel_wdata_s = inst_wdata;
        end
    end

    // Handshake completion and acknowledge generation.
    always_comb begin
        aw_fin_s  = !awvalid_q || awready;
        w_fin_s   = !wvalid_q  || wready;
        wr_fin_s  = (state_q == WR_ADDR) && aw_fin_s && w_fin_s;
        rd_done_s = (state_q == RD_DATA) && rvalid && rlast;
        rd_ok_s   = rd_done_s && (rid == id_q);
`ifdef SRAM_AXI_EARLY_WACK_EN
        wr_ack_s  = wr_fin_s;
`else
        wr_ack_s  = (state_q == WR_RESP) && bvalid;
`endif
    end

    // Next-state and latched request fields.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        id_d      = id_q;
        src_d     = src_q;
        arvalid_d = arvalid_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        case (state_q)
            IDLE: begin
                if (grant_s) begin
                    addr_d    = sel_addr_s;
                    size_d    = sel_size_s;
                    wdata_d   = sel_wdata_s;
                    wstrb_d   = calc_strb(sel_size_s, sel_addr_s[1:0]);
                    id_d      = sel_data_s ? 4'(DATA_ID) : 4'(INST_ID);
                    src_d     = sel_data_s;
                    arvalid_d = !sel_wr_s;
                    awvalid_d = sel_wr_s;
                    wvalid_d  = sel_wr_s;
                    state_d   = sel_wr_s ? WR_ADDR : RD_ADDR;
                end else begin
                    state_d   = IDLE;
                end
            end
            RD_ADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_DATA;
                end else begin
                    state_d   = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (rd_done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RD_DATA;
                end
            end
            WR_ADDR: begin
                // AW and W retire independently; move on once both are gone.
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                end else begin
                    awvalid_d = awvalid_q;
                end
                if (wvalid_q && wready) begin
                    wvalid_d = 1'b0;
                end else begin
                    wvalid_d = wvalid_q;
                end
                if (wr_fin_s) begin
                    state_d = WR_RESP;
                end else begin
                    state_d = WR_ADDR;
                end
            end
            WR_RESP: begin
                if (bvalid) begin
                    state_d = IDLE;
                end else begin
                    state_d = WR_RESP;
                end
            end
            default: begin
                state_d   = IDLE;
                arvalid_d = 1'b0;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
            end
        endcase
    end

    // State and transaction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= {ADDR_W{1'b0}};
            size_q    <= 2'd0;
            wdata_q   <= {DATA_W{1'b0}};
            wstrb_q   <= {STRB_W{1'b0}};
            id_q      <= 4'd0;
            src_q     <= 1'b0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            id_q      <= id_d;
            src_q     <= src_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
        end
    end

    assign inst_addr_ok = idle_s && inst_req && !data_req;
    assign data_addr_ok = idle_s && data_req;
    assign inst_data_ok = (rd_ok_s || wr_ack_s) && !src_q;
    assign data_data_ok = (rd_ok_s || wr_ack_s) && src_q;
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign arid    = id_q;
    assign araddr  = addr_q;
    assign arsize  = {1'b0, size_q};
    assign arvalid = arvalid_q;
    assign rready  = (state_q == RD_DATA);

    assign awid    = id_q;
    assign awaddr  = addr_q;
    assign awsize  = {1'b0, size_q};
    assign awvalid = awvalid_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wvalid  = wvalid_q;
    assign wlast   = wvalid_q;
    assign bready  = (state_q == WR_RESP);

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Scoreboard bench for sram_axi_bridge: bench acts as CPU and AXI slave with scripted timing.
module tb_sram_axi_bridge;

`ifdef SRAM_AXI_EARLY_WACK_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  arid, rid, awid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rvalid, rlast, rready;
    logic        awvalid, awready, wvalid, wlast, wready, bvalid, bready;
    logic [3:0]  wstrb;

    sram_axi_bridge dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {
        logic        port;   // 0 = inst, 1 = data
        logic        is_wr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Scoreboard: every data_ok must match the oldest expected completion.
    always @(negedge clk) begin
        if (!rst && (inst_data_ok || data_data_ok)) begin
            checks++;
            if (inst_data_ok && data_data_ok) begin
                errors++;
                $display("FAIL sb_both_ok: inst_data_ok=1 data_data_ok=1, required only one");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: data_ok inst=%0b data=%0b with nothing expected",
                         inst_data_ok, data_data_ok);
            end else begin
                mon_e = exp_q.pop_front();
                if (data_data_ok !== mon_e.port ||
                    (!mon_e.is_wr && (mon_e.port ? data_rdata : inst_rdata) !== mon_e.data)) begin
                    errors++;
                    $display("FAIL sb_result: port=%0b rdata=%h, required port=%0b rdata=%h",
                             data_data_ok, mon_e.port ? data_rdata : inst_rdata,
                             mon_e.port, mon_e.data);
                end
            end
            checks++;
            if (inst_addr_ok || data_addr_ok) begin
                errors++;
                $display("FAIL sb_addr_ok_overlap: addr_ok inst=%0b data=%0b during data_ok, required 0",
                         inst_addr_ok, data_addr_ok);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inst_req = 1'b1;
        repeat (2) cyc();
        checks++;
        if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, arvalid, awvalid, wvalid,
             rready, bready} !== 9'd0 || araddr !== 32'd0 || awaddr !== 32'd0 ||
            wstrb !== 4'd0 || arid !== 4'd0 || wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: ok/valid/ready=%b araddr=%h wstrb=%b arid=%h, required all 0",
                     {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, arvalid, awvalid,
                      wvalid, rready, bready}, araddr, wstrb, arid);
        end
        inst_req = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_inst_read();
        cyc();
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'hBFC0_0000;
        #1;
        checks++;
        if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL rd_addr_ok: inst=%b data=%b, required 1 0", inst_addr_ok, data_addr_ok);
        end
        exp_q.push_back('{1'b0, 1'b0, 32'h3C1D_0000});
        for (int k = 1; k <= 3; k++) begin
            cyc();
            inst_req = 1'b0;
            arready  = (k == 3);
            #1;
            checks++;
            if (arvalid !== 1'b1 || araddr !== 32'hBFC0_0000 || arid !== 4'd0 || arsize !== 3'd2) begin
                errors++;
                $display("FAIL rd_ar_hold t%0d: arvalid=%b araddr=%h arid=%h arsize=%0d, required 1 bfc00000 0 2",
                         k, arvalid, araddr, arid, arsize);
            end
        end
        cyc();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h3C1D_0000;
        #1;
        checks++;
        if (arvalid !== 1'b0 || rready !== 1'b1 || inst_data_ok !== 1'b1 ||
            inst_rdata !== 32'h3C1D_0000) begin
            errors++;
            $display("FAIL rd_data: arvalid=%b rready=%b data_ok=%b rdata=%h, required 0 1 1 3c1d0000",
                     arvalid, rready, inst_data_ok, inst_rdata);
        end
        cyc();
        rvalid = 1'b0;
        #1;
        checks++;
        if (rready !== 1'b0) begin
            errors++;
            $display("FAIL rd_rready_drop: rready=%b, required 0", rready);
        end
    endtask

    task automatic test_arbitration();
        cyc();
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'hBFC0_0004;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_1000;
        #1;
        checks++;
        if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL arb_grant: data=%b inst=%b, required 1 0", data_addr_ok, inst_addr_ok);
        end
        exp_q.push_back('{1'b1, 1'b0, 32'h1234_5678});
        cyc();
        data_req = 1'b0; arready = 1'b1;
        #1;
        checks++;
        if (arvalid !== 1'b1 || arid !== 4'd1 || araddr !== 32'h8000_1000 || inst_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL arb_ar: arvalid=%b arid=%h araddr=%h inst_ok=%b, required 1 1 80001000 0",
                     arvalid, arid, araddr, inst_addr_ok);
        end
        cyc();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd1; rdata = 32'h1234_5678;
        #1;
        checks++;
        if (data_data_ok !== 1'b1 || inst_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL arb_data_ok: data_ok=%b inst_addr_ok=%b, required 1 0", data_data_ok, inst_addr_ok);
        end
        cyc();
        rvalid = 1'b0;
        #1;
        checks++;
        if (inst_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL arb_inst_late: inst_addr_ok=%b, required 1", inst_addr_ok);
        end
        exp_q.push_back('{1'b0, 1'b0, 32'h0000_BEEF});
        cyc();
        inst_req = 1'b0; arready = 1'b1;
        #1;
        checks++;
        if (arid !== 4'd0 || araddr !== 32'hBFC0_0004) begin
            errors++;
            $display("FAIL arb_inst_ar: arid=%h araddr=%h, required 0 bfc00004", arid, araddr);
        end
        cyc();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h0000_BEEF;
        cyc();
        rvalid = 1'b0;
    endtask

    task automatic test_write_byte();
        cyc();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
        data_addr = 32'h8000_0003; data_wdata = 32'hAB00_0000;
        #1;
        checks++;
        if (data_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL sb_addr_ok: data_addr_ok=%b, required 1", data_addr_ok);
        end
        exp_q.push_back('{1'b1, 1'b1, 32'd0});
        cyc();
        data_req = 1'b0; wready = 1'b1;
        #1;
        checks++;
        if (awvalid !== 1'b1 || wvalid !== 1'b1 || wlast !== 1'b1 || wstrb !== 4'b1000 ||
            awsize !== 3'd0 || awaddr !== 32'h8000_0003 || wdata !== 32'hAB00_0000 || awid !== 4'd1) begin
            errors++;
            $display("FAIL sb_fields: awv=%b wv=%b wlast=%b wstrb=%b awsize=%0d awaddr=%h wdata=%h awid=%h",
                     awvalid, wvalid, wlast, wstrb, awsize, awaddr, wdata, awid);
        end
        cyc();
        wready = 1'b0;
        #1;
        checks++;
        if (wvalid !== 1'b0 || awvalid !== 1'b1) begin
            errors++;
            $display("FAIL sb_w_drop: wvalid=%b awvalid=%b, required 0 1", wvalid, awvalid);
        end
        cyc();
        #1;
        checks++;
        if (awvalid !== 1'b1 || wvalid !== 1'b0) begin
            errors++;
            $display("FAIL sb_aw_hold: awvalid=%b wvalid=%b, required 1 0", awvalid, wvalid);
        end
        cyc();
        awready = 1'b1;
        #1;
        checks++;
        if (awvalid !== 1'b1 || data_data_ok !== EARLY) begin
            errors++;
            $display("FAIL sb_aw_hs: awvalid=%b data_ok=%b, required 1 %b", awvalid, data_data_ok, EARLY);
        end
        cyc();
        awready = 1'b0;
        #1;
        checks++;
        if (awvalid !== 1'b0 || bready !== 1'b1 || data_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL sb_resp_wait: awvalid=%b bready=%b data_ok=%b, required 0 1 0",
                     awvalid, bready, data_data_ok);
        end
        cyc();
        bvalid = 1'b1;
        #1;
        checks++;
        if (data_data_ok !== !EARLY || data_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL sb_bresp: data_ok=%b addr_ok=%b, required %b 0", data_data_ok, data_addr_ok, !EARLY);
        end
        cyc();
        bvalid = 1'b0;
        #1;
        checks++;
        if (bready !== 1'b0) begin
            errors++;
            $display("FAIL sb_bready_drop: bready=%b, required 0", bready);
        end
    endtask

    task automatic do_write(input logic [1:0] sz, input logic [31:0] addr,
                            input logic [3:0] exp_strb, input logic [2:0] exp_size);
        cyc();
        data_req = 1'b1; data_wr = 1'b1; data_size = sz; data_addr = addr; data_wdata = 32'hCAFE_F00D;
        #1;
        checks++;
        if (data_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL wr_addr_ok %h: data_addr_ok=%b, required 1", addr, data_addr_ok);
        end
        exp_q.push_back('{1'b1, 1'b1, 32'd0});
        cyc();
        data_req = 1'b0; awready = 1'b1; wready = 1'b1;
        #1;
        checks++;
        if (wstrb !== exp_strb || awsize !== exp_size || awvalid !== 1'b1 || wvalid !== 1'b1 ||
            data_data_ok !== EARLY) begin
            errors++;
            $display("FAIL wr_strb size%0d @%h: wstrb=%b awsize=%0d awv=%b wv=%b ok=%b, required %b %0d 1 1 %b",
                     sz, addr, wstrb, awsize, awvalid, wvalid, data_data_ok, exp_strb, exp_size, EARLY);
        end
        cyc();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        #1;
        checks++;
        if (bready !== 1'b1 || data_data_ok !== !EARLY) begin
            errors++;
            $display("FAIL wr_bresp @%h: bready=%b data_ok=%b, required 1 %b", addr, bready, data_data_ok, !EARLY);
        end
        cyc();
        bvalid = 1'b0;
    endtask

    task automatic test_write_sizes();
        do_write(2'd1, 32'h8000_0002, 4'b1100, 3'd1);
        do_write(2'd2, 32'h8000_0000, 4'b1111, 3'd2);
        do_write(2'd0, 32'h8000_0001, 4'b0010, 3'd0);
        do_write(2'd1, 32'h8000_0000, 4'b0011, 3'd1);
        do_write(2'd3, 32'h8000_0003, 4'b1111, 3'd3);
    endtask

    task automatic test_reset_mid();
        cyc();
        inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'hBFC0_0010;
        #1;
        checks++;
        if (inst_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_addr_ok: inst_addr_ok=%b, required 1", inst_addr_ok);
        end
        cyc();
        inst_req = 1'b0; arready = 1'b1;
        cyc();
        arready = 1'b0;
        #1;
        checks++;
        if (rready !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_rready: rready=%b, required 1", rready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rready, arvalid, awvalid, wvalid, bready, inst_data_ok, data_data_ok} !== 7'd0 ||
            araddr !== 32'd0 || arid !== 4'd0) begin
            errors++;
            $display("FAIL rst_async: ready/valid/ok=%b araddr=%h arid=%h, required all 0",
                     {rready, arvalid, awvalid, wvalid, bready, inst_data_ok, data_data_ok}, araddr, arid);
        end
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0020;
        #1;
        checks++;
        if (inst_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL rst_post_addr_ok: inst_addr_ok=%b, required 1", inst_addr_ok);
        end
        exp_q.push_back('{1'b0, 1'b0, 32'h2408_0001});
        cyc();
        inst_req = 1'b0; arready = 1'b1;
        cyc();
        arready = 1'b0; rvalid = 1'b1; rid = 4'd0; rdata = 32'h2408_0001;
        cyc();
        rvalid = 1'b0;
    endtask

    task automatic test_late_bresp();
        cyc();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
        data_addr = 32'h8000_0100; data_wdata = 32'h5555_AAAA;
        #1;
        checks++;
        if (data_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL late_addr_ok: data_addr_ok=%b, required 1", data_addr_ok);
        end
        exp_q.push_back('{1'b1, 1'b1, 32'd0});
        cyc();
        awready = 1'b1; wready = 1'b1;
        #1;
        checks++;
        if (data_data_ok !== EARLY || data_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL late_aw_w: data_ok=%b addr_ok=%b, required %b 0", data_data_ok, data_addr_ok, EARLY);
        end
        for (int k = 0; k < 5; k++) begin
            cyc();
            awready = 1'b0; wready = 1'b0;
            #1;
            checks++;
            if (data_addr_ok !== 1'b0 || data_data_ok !== 1'b0) begin
                errors++;
                $display("FAIL late_wait %0d: addr_ok=%b data_ok=%b, required 0 0", k, data_addr_ok, data_data_ok);
            end
        end
        cyc();
        bvalid = 1'b1;
        #1;
        checks++;
        if (data_data_ok !== !EARLY || data_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL late_bvalid: data_ok=%b addr_ok=%b, required %b 0", data_data_ok, data_addr_ok, !EARLY);
        end
        cyc();
        bvalid = 1'b0;
        #1;
        checks++;
        if (data_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL late_next_grant: data_addr_ok=%b, required 1", data_addr_ok);
        end
        exp_q.push_back('{1'b1, 1'b1, 32'd0});
        cyc();
        data_req = 1'b0; awready = 1'b1; wready = 1'b1;
        cyc();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
        cyc();
        bvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_addr = 32'd0; inst_wdata = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
        arready = 1'b0; rid = 4'd0; rdata = 32'd0; rvalid = 1'b0; rlast = 1'b1;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

        test_reset();
        test_inst_read();
        test_arbitration();
        test_write_byte();
        test_write_sizes();
        test_reset_mid();
        test_late_bresp();
        repeat (3) cyc();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d completions outstanding, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
